// File: rtl/xswitch_rr_pkg.sv
// xswitch_rr_pkg: shared widths, counter limits, entry type and port-index helper for the crossbar
package xswitch_rr_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
  localparam int ENTRY_ADDR_W = 8;
  localparam int ENTRY_DATA_W = 8;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;
  function automatic int port_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/xswitch_rr_fifo.sv
// xswitch_rr_fifo: single-clock input FIFO; ports clk, reset, push/din in, pop in, head/count/ready out (ready registered)
module xswitch_rr_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] nxt;
  always_comb nxt = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= nxt;
      ready <= nxt != CW'(DEPTH);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign head = mem[rp];
endmodule

// File: rtl/xswitch_rr.sv
// xswitch_rr: NPORTS x NPORTS crossbar with per-input FIFOs, per-output round-robin arbiters and valid/ready outputs.
// Ports: clk, reset (async high), data_in/addr_in/valid_in + data_rd per input, data_out/addr_out/valid_out + rcv_rdy per output,
// pkt_cnt (per-output delivered counters) only when XSWITCH_RR_STATS_EN is defined.
module xswitch_rr
  import xswitch_rr_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS*DATA_W-1:0]   data_in,
  input  logic [NPORTS*ADDR_W-1:0]   addr_in,
  input  logic [NPORTS-1:0]          valid_in,
  output logic [NPORTS-1:0]          data_rd,
  output logic [NPORTS*DATA_W-1:0]   data_out,
  output logic [NPORTS*ADDR_W-1:0]   addr_out,
  output logic [NPORTS-1:0]          valid_out,
`ifdef XSWITCH_RR_STATS_EN
  output logic [NPORTS*CNT_W-1:0]    pkt_cnt,
`endif
  input  logic [NPORTS-1:0]          rcv_rdy
);
  localparam int PW = port_w(NPORTS);
  localparam int W = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] head [NPORTS];
  logic [CW-1:0] cnt [NPORTS];
  logic [NPORTS-1:0] hv, pop, drop, gv, load;
  logic [NPORTS-1:0] req [NPORTS];
  logic [PW-1:0] gi [NPORTS];
  logic [PW-1:0] ptr [NPORTS];
  logic [DATA_W-1:0] dq [NPORTS];
  logic [ADDR_W-1:0] aq [NPORTS];
  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    xswitch_rr_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(valid_in[i] & data_rd[i]),
      .din({addr_in[i*ADDR_W +: ADDR_W], data_in[i*DATA_W +: DATA_W]}),
      .pop(pop[i]),
      .head(head[i]),
      .count(cnt[i]),
      .ready(data_rd[i])
    );
    assign hv[i] = |cnt[i];
  end
  // req[j][i]: head of FIFO i is addressed to output j. A head matching no
  // output (dest >= NPORTS) is dropped by popping it without a grant.
  always_comb begin
    drop = hv;
    for (int j = 0; j < NPORTS; j++) begin
      load[j] = !valid_out[j] | rcv_rdy[j];
      for (int i = 0; i < NPORTS; i++) begin
        req[j][i] = hv[i] && head[i][DATA_W +: PW] == PW'(j);
        if (req[j][i]) drop[i] = 1'b0;
      end
    end
    pop = drop;
    for (int j = 0; j < NPORTS; j++) begin
      gv[j] = 1'b0;
      gi[j] = '0;
      for (int k = 0; k < NPORTS; k++)
        if (load[j] && !gv[j] && req[j][(int'(ptr[j]) + k) % NPORTS]) begin
          gv[j] = 1'b1;
          gi[j] = PW'((int'(ptr[j]) + k) % NPORTS);
        end
      if (gv[j]) pop[gi[j]] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_out <= '0;
      for (int j = 0; j < NPORTS; j++) begin
        dq[j] <= '0;
        aq[j] <= '0;
        ptr[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++)
        if (gv[j]) begin
          dq[j] <= head[gi[j]][DATA_W-1:0];
          aq[j] <= head[gi[j]][W-1:DATA_W];
          valid_out[j] <= 1'b1;
          ptr[j] <= gi[j] == PW'(NPORTS-1) ? '0 : gi[j] + PW'(1);
        end else if (rcv_rdy[j]) valid_out[j] <= 1'b0;
    end
  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    assign data_out[j*DATA_W +: DATA_W] = dq[j];
    assign addr_out[j*ADDR_W +: ADDR_W] = aq[j];
  end
`ifdef XSWITCH_RR_STATS_EN
  logic [CNT_W-1:0] pc [NPORTS];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int j = 0; j < NPORTS; j++) pc[j] <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++)
        if (valid_out[j] && rcv_rdy[j] && pc[j] != CNT_MAX) pc[j] <= pc[j] + 1'b1;
    end
  for (genvar j = 0; j < NPORTS; j++) begin : g_cnt
    assign pkt_cnt[j*CNT_W +: CNT_W] = pc[j];
  end
`endif
endmodule

// File: tb/tb_xswitch_rr.sv
// tb_xswitch_rr: self-checking bench for xswitch_rr (4-port and 3-port instances) against a queue-based reference model
module tb_xswitch_rr;
  import xswitch_rr_pkg::*;
  localparam int D = 4;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;
  logic [31:0] din [2];
  logic [31:0] ain [2];
  logic [3:0] vin [2];
  logic [3:0] rdy [2];
  wire [3:0] drd0, vo0;
  wire [2:0] drd1, vo1;
  wire [31:0] do0, ao0;
  wire [23:0] do1, ao1;
`ifdef XSWITCH_RR_STATS_EN
  wire [63:0] pc0;
  wire [47:0] pc1;
`endif
  xswitch_rr #(.NPORTS(4), .DATA_W(8), .ADDR_W(8), .DEPTH(D)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .addr_in(ain[0]), .valid_in(vin[0]),
    .data_rd(drd0), .data_out(do0), .addr_out(ao0), .valid_out(vo0),
`ifdef XSWITCH_RR_STATS_EN
    .pkt_cnt(pc0),
`endif
    .rcv_rdy(rdy[0]));
  xswitch_rr #(.NPORTS(3), .DATA_W(8), .ADDR_W(8), .DEPTH(D)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1][23:0]), .addr_in(ain[1][23:0]), .valid_in(vin[1][2:0]),
    .data_rd(drd1), .data_out(do1), .addr_out(ao1), .valid_out(vo1),
`ifdef XSWITCH_RR_STATS_EN
    .pkt_cnt(pc1),
`endif
    .rcv_rdy(rdy[1][2:0]));
  int tests = 0;
  int fails = 0;
  entry_t q [2][4][$];
  bit mv [2][4];
  entry_t mo [2][4];
  int mp [2][4];
  int mc [2][4];
  bit mrd [2][4];
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic void mclear();
    for (int u = 0; u < 2; u++)
      for (int j = 0; j < 4; j++) begin
        q[u][j].delete();
        mv[u][j] = 0;
        mo[u][j] = '0;
        mp[u][j] = 0;
        mc[u][j] = 0;
        mrd[u][j] = 0;
      end
  endfunction
  // One clock edge of the switch: arbitrate on pre-edge heads, then pop, then push.
  function automatic void medge();
    for (int u = 0; u < 2; u++) begin
      int n = u ? 3 : 4;
      bit pop [4] = '{default: 0};
      for (int j = 0; j < n; j++) begin
        int g = -1;
        if (mv[u][j] && rdy[u][j]) mc[u][j] = mc[u][j] == 65535 ? 65535 : mc[u][j] + 1;
        if (!mv[u][j] || rdy[u][j])
          for (int k = 0; k < n; k++) begin
            int i = (mp[u][j] + k) % n;
            if (g < 0 && q[u][i].size() > 0 && int'(q[u][i][0].addr[1:0]) == j) g = i;
          end
        if (g >= 0) begin
          pop[g] = 1;
          mo[u][j] = q[u][g][0];
          mv[u][j] = 1;
          mp[u][j] = (g + 1) % n;
        end else if (rdy[u][j]) mv[u][j] = 0;
      end
      for (int i = 0; i < n; i++)
        if (q[u][i].size() > 0 && int'(q[u][i][0].addr[1:0]) >= n) pop[i] = 1;
      for (int i = 0; i < n; i++) begin
        if (pop[i]) void'(q[u][i].pop_front());
        if (vin[u][i] && mrd[u][i]) q[u][i].push_back(entry_t'{addr: ain[u][i*8 +: 8], data: din[u][i*8 +: 8]});
        mrd[u][i] = q[u][i].size() != D;
      end
    end
  endfunction
  task automatic check_all();
    logic [31:0] ed [2];
    logic [31:0] ea [2];
    logic [3:0] ev [2];
    logic [3:0] er [2];
    logic [63:0] ep [2];
    for (int u = 0; u < 2; u++) begin
      ed[u] = '0; ea[u] = '0; ev[u] = '0; er[u] = '0; ep[u] = '0;
      for (int j = 0; j < (u ? 3 : 4); j++) begin
        ev[u][j] = mv[u][j];
        er[u][j] = mrd[u][j];
        ed[u][j*8 +: 8] = mo[u][j].data;
        ea[u][j*8 +: 8] = mo[u][j].addr;
        ep[u][j*16 +: 16] = 16'(mc[u][j]);
      end
    end
    chk("u0 data_rd", drd0, er[0]);
    chk("u0 valid_out", vo0, ev[0]);
    chk("u0 data_out", do0, ed[0]);
    chk("u0 addr_out", ao0, ea[0]);
    chk("u1 data_rd", drd1, er[1]);
    chk("u1 valid_out", vo1, ev[1]);
    chk("u1 data_out", do1, ed[1]);
    chk("u1 addr_out", ao1, ea[1]);
`ifdef XSWITCH_RR_STATS_EN
    chk("u0 pkt_cnt", pc0, ep[0]);
    chk("u1 pkt_cnt", pc1, ep[1]);
`endif
  endtask
  task automatic cyc();
    @(posedge clk);
    if (reset) mclear(); else medge();
    #1 check_all();
  endtask
  task automatic drv(input int u, input int i, input bit v, input logic [7:0] a, input logic [7:0] d);
    vin[u][i] = v;
    ain[u][i*8 +: 8] = a;
    din[u][i*8 +: 8] = d;
  endtask
  task automatic idle();
    vin[0] = '0;
    vin[1] = '0;
  endtask
  initial begin
    int src [$];
    int seen [$];
    bit pend;
    int b;
    reset = 0;
    for (int u = 0; u < 2; u++) begin
      din[u] = '0; ain[u] = '0; vin[u] = '0; rdy[u] = 4'hF;
    end
    mclear();
    #1 reset = 1;
    #1;
    chk("reset valid_out", vo0, 0);
    chk("reset data_rd", drd0, 0);
    chk("reset data_out", do0, 0);
    repeat (3) cyc();
    reset = 0;
    cyc();
    chk("rd after release", drd0, 4'hF);
    // single word port 0 -> output 2
    drv(0, 0, 1, 8'h02, 8'hA5);
    cyc();
    idle();
    cyc();
    chk("single valid", vo0, 4'b0100);
    chk("single data", do0[23:16], 8'hA5);
    chk("single addr", ao0[23:16], 8'h02);
    cyc();
    // backpressure and fill: port 3 -> output 1 with output 1 stalled
    rdy[0] = 4'b1101;
    for (int w = 0; w < 5; w++) begin
      drv(0, 3, 1, 8'h01, 8'(w));
      b = 0;
      while (!drd0[3] && b < 10) begin cyc(); b++; end
      chk("fill wait", b < 10, 1);
      cyc();
    end
    chk("full data_rd", drd0[3], 0);
    chk("full valid", vo0[1], 1);
    chk("full head word", do0[15:8], 0);
    drv(0, 3, 1, 8'h01, 8'd5);
    repeat (3) cyc();
    rdy[0] = 4'hF;
    pend = 1;
    for (int w = 1; w < 6; w++) begin
      if (drd0[3]) pend = 0;
      cyc();
      if (!pend) vin[0][3] = 0;
      chk("drain order", do0[15:8], 8'(w));
      chk("drain valid", vo0[1], 1);
    end
    idle();
    repeat (4) cyc();
    // round-robin fairness: all inputs to output 0
    for (int i = 0; i < 4; i++) drv(0, i, 1, 8'h00, {4'($urandom), 4'(i)});
    repeat (16) begin
      cyc();
      if (vo0[0]) src.push_back(int'(do0[3:0]));
    end
    for (int k = 0; k < 8; k++) chk("rr source", k < src.size() ? src[k] : 99, k % 4);
    idle();
    repeat (24) cyc();
    // parallel non-conflicting traffic: input i -> output (i+1)%4
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) drv(0, i, 1, 8'((i + 1) % 4), 8'($urandom));
      cyc();
      if (c >= 2) chk("parallel valid", vo0, 4'hF);
    end
    idle();
    repeat (4) cyc();
    // mid-operation reset
    rdy[0] = 4'h0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) drv(0, i, 1, 8'h00, 8'($urandom));
      cyc();
    end
    chk("pre-reset valid", vo0[0], 1);
    idle();
    #3 reset = 1;
    #1;
    chk("async valid_out", vo0, 0);
    chk("async data_out", do0, 0);
    chk("async addr_out", ao0, 0);
    chk("async data_rd", drd0, 0);
    mclear();
    check_all();
    rdy[0] = 4'hF;
    repeat (2) cyc();
    reset = 0;
    cyc();
    chk("rd after mid reset", drd0, 4'hF);
    repeat (3) cyc();
    chk("no stale word", vo0, 0);
    // 3-port instance: 5 words to output 2, one word with dest 3 (dropped)
    for (int w = 0; w < 5; w++) begin
      drv(1, 0, 1, 8'h02, 8'($urandom));
      drv(1, 1, w == 0, 8'h03, 8'hEE);
      cyc();
    end
    idle();
    repeat (6) cyc();
    chk("drop fifo empty", drd1, 3'b111);
`ifdef XSWITCH_RR_STATS_EN
    chk("stats counts", pc1, {16'd5, 16'd0, 16'd0});
`endif
    // random traffic on both instances
    repeat (300) begin
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < 4; i++) drv(u, i, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int j = 0; j < 4; j++) rdy[u][j] = ($urandom % 4) != 0;
      end
      cyc();
    end
    idle();
    rdy[0] = 4'hF;
    rdy[1] = 4'hF;
    repeat (24) cyc();
    seen.push_back(tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xswitch_rr.md
# xswitch_rr

Parametrised N×N packet crossbar. It is the next generation of the fixed 4-port `xswitch`, and `dut_top` wraps it for block-level verification. Each input port has a DEPTH-entry FIFO. A round-robin arbiter on each output selects among input FIFO heads addressed to that output. Outputs use a valid/ready handshake with per-port backpressure.

## Interface
Parameters:
- NPORTS, default 4: number of input ports and output ports; valid range 2..16.
- DATA_W, default 8: payload width.
- ADDR_W, default 8: address width. Destination port is addr[PW-1:0], where PW = $clog2(NPORTS). ADDR_W ≥ PW.
- DEPTH, default 4: entries per input FIFO; power of 2, ≥ 2.

Ports (packed buses; port i occupies slice [i*W +: W]):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  NPORTS*DATA_W  input payloads.
- addr_in  in  NPORTS*ADDR_W  input addresses.
- valid_in  in  NPORTS  input valid.
- data_rd  out  NPORTS  input ready (registered); a transfer occurs when valid_in[i] & data_rd[i] at an edge.
- data_out  out  NPORTS*DATA_W  output payloads.
- addr_out  out  NPORTS*ADDR_W  output addresses, passed through unchanged.
- valid_out  out  NPORTS  output valid.
- rcv_rdy  in  NPORTS  receiver ready; consumption occurs when valid_out[j] & rcv_rdy[j] at an edge.
- pkt_cnt  out  NPORTS*16  delivered-packet counters; present only when XSWITCH_RR_STATS_EN is defined.

## Operation
- **Input FIFO i:**
  - Holds {addr, data} and a count from 0 to DEPTH.
  - data_rd[i] = (count != DEPTH), driven from a register; there is no combinational path from rcv_rdy or valid_in.
  - Push and pop may occur in the same cycle. When that happens the count is unchanged.
- **Invalid destination** (dest ≥ NPORTS, possible only when NPORTS is not a power of 2): the word is still accepted, is popped on the next cycle without output, and is never delivered.
- **Output register j:**
  - It is loadable when !valid_out[j] | rcv_rdy[j].
  - When loadable, the arbiter for j considers the FIFO heads with count > 0 and dest == j, and grants the first requester at or after rr_ptr[j], searching cyclically.
  - On a grant: the output register loads the head, valid_out[j] is set to 1, the head of FIFO i is popped, and rr_ptr[j] becomes (i+1) mod NPORTS.
  - When there is no grant and the current word is consumed, valid_out[j] drops to 0.
- **Held outputs:** valid_out[j], data_out and addr_out stay stable until consumed.
- **Head-of-line blocking** is accepted; only the head of each FIFO is visible to the arbiters.
- **Grant exclusivity:** a FIFO head targets exactly one output, so an input can never receive two grants in one cycle.
- **Reset values:**
  - All FIFO counts 0.
  - rr_ptr = 0.
  - valid_out = 0, data_out = 0, addr_out = 0.
  - data_rd = 0.
  - pkt_cnt = 0.

## Timing
- data_rd rises on the first clk edge after reset deasserts.
- **Latency**, uncontended with an empty FIFO: word accepted at edge k, head visible during cycle k, output loaded at edge k+1. valid_out is therefore high in the cycle after acceptance.
- **Throughput:** one word per cycle per input and one word per cycle per output, sustained, while rcv_rdy is held high.
- **Full FIFO:** when a push leaves the count at DEPTH, data_rd is low from the next cycle. A pop with no push raises data_rd after one edge.
- **Contention:** with k inputs targeting one output and rcv_rdy held high, each requester is served once every k cycles, in strict rotation.
- **Reset mid-operation:** all in-flight words are discarded immediately (asynchronous) and outputs return to their reset values.

## Configuration
- XSWITCH_RR_STATS_EN defined:
  - Adds the pkt_cnt port.
  - pkt_cnt[j] increments on each consumption on output j and saturates at 16'hFFFF.
- Not defined: the port and the counters are absent, and switching behaviour is identical.

## Structure
- **Package xswitch_rr_pkg:**
  - localparam helper function port_w(n) = $clog2(n).
  - typedef of the FIFO entry struct {addr, data}, parameterised through macros or package parameters.
  - CNT_W = 16 and CNT_MAX.
- **One sub-module, xswitch_rr_fifo:**
  - Single-clock FIFO of depth DEPTH.
  - Exposes count, head and pop.
  - The top level instantiates it NPORTS times and contains the arbiters and output registers.

## Test plan
- **Reset then single word:** reset 3 cycles, then drive port 0 with addr 8'h02 and data 8'hA5 for one cycle. Required: data_rd high after the first edge; valid_out[2] high the next cycle with data 8'hA5 and addr 8'h02; every other valid_out stays 0.
- **Backpressure and fill:** hold rcv_rdy[1] = 0 and stream 6 words from port 3 to dest 1 with DEPTH = 4. Required: 1 word in the output register, 4 in the FIFO, and data_rd[3] low after the 5th accept. Then raise rcv_rdy: words 0..5 arrive in order, one per cycle.
- **Round-robin fairness:** all 4 inputs continuously send to port 0 with rcv_rdy[0] = 1. Required: the sequence of source ports is 0,1,2,3,0,1,…, with no input served twice before the others.
- **Parallel non-conflicting traffic:** input i sends to output (i+1)%4 every cycle. Required: all valid_out continuously high, 1 word per cycle per port, data in order.
- **Mid-operation reset:** assert reset while 3 FIFOs are partially full and valid_out[0] is high. Required: outputs become 0 asynchronously, no stale word appears after release, and data_rd returns high after 1 edge.
- **Stats:** with XSWITCH_RR_STATS_EN defined and NPORTS = 3, deliver 5 words to port 2 and send 1 word with dest 3. Required: pkt_cnt[2] = 5, the other counters 0, the dest-3 word dropped, and that FIFO empty afterwards.
